// File: rtl/sr_pkg.sv
// sr_pkg: state encoding and default timing parameters shared by sr_drive and sr_debounce
package sr_pkg;
  typedef enum logic [1:0] {IDLE, DRIVE_S, DRIVE_R, CHECK} state_t;
  localparam int DB_CYCLES_DEF = 4;
  localparam int PULSE_LEN_DEF = 1;
endpackage

// File: rtl/sr_drive_debounce.sv
// sr_debounce: 2-flop synchronizer, counting debouncer and rising-edge detect for one button
module sr_debounce import sr_pkg::*; #(
  parameter int DB_CYCLES = DB_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_btn,
  output logic o_rise
);
  logic       r_sync1, r_sync2, r_level, r_level_d;
  logic [7:0] r_cnt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1   <= 1'b0;
      r_sync2   <= 1'b0;
      r_level   <= 1'b0;
      r_level_d <= 1'b0;
      r_cnt     <= 8'd0;
    end else begin
      r_sync1   <= i_btn;
      r_sync2   <= r_sync1;
      r_level_d <= r_level;
      // any cycle agreeing with the accepted level restarts the stability count
      if (r_sync2 == r_level) r_cnt <= 8'd0;
      else if (r_cnt == 8'(DB_CYCLES - 1)) begin
        r_level <= r_sync2;
        r_cnt   <= 8'd0;
      end else r_cnt <= r_cnt + 8'd1;
    end
  end
  assign o_rise = r_level & ~r_level_d;
endmodule

// File: rtl/sr_drive.sv
// sr_drive: debounced set/reset buttons drive an external sr_ff with one-hot pulses and verify its q
module sr_drive import sr_pkg::*; #(
  parameter int DB_CYCLES = DB_CYCLES_DEF,
  parameter int PULSE_LEN = PULSE_LEN_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       set_btn,
  input  logic       rst_btn,
  input  logic       q,
  output logic       s,
  output logic       r,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic       conflict,
  output logic [7:0] err_cnt
);
  state_t     r_state;
  logic [3:0] r_pcnt;
  logic       r_s, r_r, r_busy, r_done, r_err, r_conflict, r_expect;
  logic [7:0] r_err_cnt;
  logic       w_set_rise, w_rst_rise;
  sr_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_set (.clk(clk), .rst_n(rst_n), .i_btn(set_btn), .o_rise(w_set_rise));
  sr_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_rst (.clk(clk), .rst_n(rst_n), .i_btn(rst_btn), .o_rise(w_rst_rise));
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_pcnt     <= 4'd0;
      r_s        <= 1'b0;
      r_r        <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_conflict <= 1'b0;
      r_expect   <= 1'b0;
      r_err_cnt  <= 8'd0;
    end else begin
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_conflict <= 1'b0;
      // rises outside IDLE fall through every branch and are dropped
      case (r_state)
        IDLE: begin
          r_pcnt <= 4'd0;
          if (w_set_rise && w_rst_rise) r_conflict <= 1'b1;
          else if (w_set_rise || w_rst_rise) begin
            r_state  <= w_set_rise ? DRIVE_S : DRIVE_R;
            r_s      <= w_set_rise;
            r_r      <= w_rst_rise;
            r_expect <= w_set_rise;
            r_busy   <= 1'b1;
          end
        end
        DRIVE_S, DRIVE_R: begin
          if (r_pcnt == 4'(PULSE_LEN - 1)) begin
            r_state <= CHECK;
            r_s     <= 1'b0;
            r_r     <= 1'b0;
          end else r_pcnt <= r_pcnt + 4'd1;
        end
        CHECK: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_done  <= (q == r_expect);
          r_err   <= (q != r_expect);
          if (q != r_expect && r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  assign s        = r_s;
  assign r        = r_r;
  assign busy     = r_busy;
  assign done     = r_done;
  assign err      = r_err;
  assign conflict = r_conflict;
  assign err_cnt  = r_err_cnt;
endmodule
